// File: rtl/tnn_frame_sequencer.sv
// Serial feature collector and valid/ready result channel for a combinational TNN core.
// Define TNN_FRAME_STATS_EN to add saturating stat_frames/stat_pos/stat_err counters.
module tnn_frame_sequencer #(
  parameter int NUM_FEATURES = 5,
  parameter int FEAT_W       = 2,
  parameter int EVAL_CYCLES  = 2,
  parameter int CNT_W        = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [FEAT_W-1:0]              s_data,
  input  logic                           s_last,
  output logic [NUM_FEATURES*FEAT_W-1:0] feat_vec,
  input  logic                           core_out,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic                           m_class,
  output logic                           m_err,
`ifdef TNN_FRAME_STATS_EN
  output logic [CNT_W-1:0]               stat_frames,
  output logic [CNT_W-1:0]               stat_pos,
  output logic [CNT_W-1:0]               stat_err,
`endif
  output logic                           busy
);

  localparam int IDX_W = $clog2(NUM_FEATURES);
  localparam int WC_W  = $clog2(EVAL_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_FEATURES - 1);
  localparam logic [WC_W-1:0]  WLAST = WC_W'(EVAL_CYCLES - 1);

  if (NUM_FEATURES < 2) begin : g_bad_nf
    $error("NUM_FEATURES must be >= 2");
  end
  if (EVAL_CYCLES < 1) begin : g_bad_ec
    $error("EVAL_CYCLES must be >= 1");
  end
  if (CNT_W < 1) begin : g_bad_cw
    $error("CNT_W must be >= 1");
  end

  typedef enum logic [1:0] {
    COLLECT,
    DRAIN,
    EVAL,
    HOLD
  } state_t;

  state_t                          state, state_nxt;
  logic [IDX_W-1:0]                idx, idx_nxt;
  logic [WC_W-1:0]                 wcnt, wcnt_nxt;
  logic [NUM_FEATURES*FEAT_W-1:0]  vec_nxt;
  logic                            err_flag, err_nxt;
  logic                            mv_nxt, mc_nxt, me_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= COLLECT;
      idx      <= '0;
      wcnt     <= '0;
      feat_vec <= '0;
      err_flag <= 1'b0;
      m_valid  <= 1'b0;
      m_class  <= 1'b0;
      m_err    <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      wcnt     <= wcnt_nxt;
      feat_vec <= vec_nxt;
      err_flag <= err_nxt;
      m_valid  <= mv_nxt;
      m_class  <= mc_nxt;
      m_err    <= me_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    wcnt_nxt  = wcnt;
    vec_nxt   = feat_vec;
    err_nxt   = err_flag;
    mv_nxt    = m_valid;
    mc_nxt    = m_class;
    me_nxt    = m_err;
    s_ready   = 1'b0;
    unique case (state)
      COLLECT: begin
        s_ready = 1'b1;
        if (s_valid) begin
          vec_nxt[int'(idx)*FEAT_W +: FEAT_W] = s_data;
          if (s_last) begin
            // A short frame must not leak stale slots from the previous frame.
            if (idx != LAST) begin
              err_nxt = 1'b1;
              for (int k = 0; k < NUM_FEATURES; k++) begin
                if (k > int'(idx)) vec_nxt[k*FEAT_W +: FEAT_W] = '0;
              end
            end
            wcnt_nxt  = '0;
            state_nxt = EVAL;
          end else if (idx == LAST) begin
            err_nxt   = 1'b1;
            state_nxt = DRAIN;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      DRAIN: begin
        s_ready = 1'b1;
        if (s_valid && s_last) begin
          wcnt_nxt  = '0;
          state_nxt = EVAL;
        end
      end
      EVAL: begin
        if (wcnt == WLAST) begin
          mv_nxt    = 1'b1;
          mc_nxt    = core_out;
          me_nxt    = err_flag;
          state_nxt = HOLD;
        end else begin
          wcnt_nxt = wcnt + 1'b1;
        end
      end
      HOLD: begin
        if (m_ready) begin
          mv_nxt    = 1'b0;
          idx_nxt   = '0;
          err_nxt   = 1'b0;
          state_nxt = COLLECT;
        end
      end
      default: state_nxt = COLLECT;
    endcase
  end

  assign busy = !((state == COLLECT) && (idx == '0));

`ifdef TNN_FRAME_STATS_EN
  logic hs;
  assign hs = m_valid & m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_frames <= '0;
      stat_pos    <= '0;
      stat_err    <= '0;
    end else if (hs) begin
      if (stat_frames != '1) stat_frames <= stat_frames + 1'b1;
      if (m_class && stat_pos != '1) stat_pos <= stat_pos + 1'b1;
      if (m_err && stat_err != '1) stat_err <= stat_err + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_tnn_frame_sequencer.sv
// Directed self-checking bench for tnn_frame_sequencer.
// Core model: class 1 when even-slot feature sum exceeds odd-slot sum.
module tb_tnn_frame_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s_valid, s_ready, s_last;
  logic [1:0] s_data;
  logic [9:0] feat_vec;
  logic       core_out;
  logic       m_valid, m_ready, m_class, m_err, busy;
`ifdef TNN_FRAME_STATS_EN
  logic [2:0] stat_frames, stat_pos, stat_err;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  logic [3:0] ev_sum, od_sum;
  assign ev_sum = 4'(feat_vec[1:0]) + 4'(feat_vec[5:4]) + 4'(feat_vec[9:8]);
  assign od_sum = 4'(feat_vec[3:2]) + 4'(feat_vec[7:6]);
  assign core_out = (ev_sum > od_sum);

  tnn_frame_sequencer #(
    .NUM_FEATURES(5),
    .FEAT_W(2),
    .EVAL_CYCLES(2),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data(s_data),
    .s_last(s_last),
    .feat_vec(feat_vec),
    .core_out(core_out),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_class(m_class),
    .m_err(m_err),
`ifdef TNN_FRAME_STATS_EN
    .stat_frames(stat_frames),
    .stat_pos(stat_pos),
    .stat_err(stat_err),
`endif
    .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] d, input logic l);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic frame5(input logic [1:0] d0, input logic [1:0] d1,
                        input logic [1:0] d2, input logic [1:0] d3,
                        input logic [1:0] d4);
    send(d0, 1'b0);
    send(d1, 1'b0);
    send(d2, 1'b0);
    send(d3, 1'b0);
    send(d4, 1'b1);
  endtask

  task automatic take(input string tag, input logic c, input logic e);
    int n = 0;
    while (m_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_valid"}, 32'(m_valid), 32'd1);
    check({tag, "_class"}, 32'(m_class), 32'(c));
    check({tag, "_err"}, 32'(m_err), 32'(e));
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    check({tag, "_released"}, 32'(m_valid), 32'd0);
    check({tag, "_sready"}, 32'(s_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = 2'd0;
    s_last  = 1'b0;
    m_ready = 1'b0;
    #12;
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_feat_vec", 32'(feat_vec), 32'd0);
    check("rst_m_class", 32'(m_class), 32'd0);
    check("rst_m_err", 32'(m_err), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    send(2'd1, 1'b0);
    check("first_beat_busy", 32'(busy), 32'd1);
    send(2'd2, 1'b0);
    send(2'd3, 1'b0);
    send(2'd0, 1'b0);
    send(2'd2, 1'b1);
    check("norm_vec", 32'(feat_vec), 32'(10'b10_00_11_10_01));
    check("norm_eval_sready", 32'(s_ready), 32'd0);
    check("norm_lat0", 32'(m_valid), 32'd0);
    @(posedge clk); #1;
    check("norm_lat1", 32'(m_valid), 32'd0);
    @(posedge clk); #1;
    check("norm_lat2", 32'(m_valid), 32'd1);
    check("norm_class", 32'(m_class), 32'd1);
    check("norm_err", 32'(m_err), 32'd0);
    repeat (10) begin
      @(posedge clk); #1;
      check("bp_valid", 32'(m_valid), 32'd1);
      check("bp_class", 32'(m_class), 32'd1);
      check("bp_err", 32'(m_err), 32'd0);
      check("bp_sready", 32'(s_ready), 32'd0);
    end
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    check("bp_done_valid", 32'(m_valid), 32'd0);
    check("bp_done_sready", 32'(s_ready), 32'd1);
    check("bp_done_busy", 32'(busy), 32'd0);

    send(2'd3, 1'b0);
    send(2'd3, 1'b1);
    check("short_vec", 32'(feat_vec), 32'(10'b00_00_00_11_11));
    take("short", 1'b0, 1'b1);

    send(2'd1, 1'b0);
    send(2'd0, 1'b0);
    send(2'd1, 1'b0);
    send(2'd0, 1'b0);
    send(2'd1, 1'b0);
    check("long_drain_sready", 32'(s_ready), 32'd1);
    check("long_drain_busy", 32'(busy), 32'd1);
    send(2'd3, 1'b0);
    send(2'd3, 1'b1);
    check("long_vec", 32'(feat_vec), 32'(10'b01_00_01_00_01));
    take("long", 1'b1, 1'b1);

    frame5(2'd0, 2'd3, 2'd0, 2'd3, 2'd1);
    check("clean_vec", 32'(feat_vec), 32'(10'b01_11_00_11_00));
    take("clean", 1'b0, 1'b0);
`ifdef TNN_FRAME_STATS_EN
    check("stat_frames_4", 32'(stat_frames), 32'd4);
    check("stat_pos_4", 32'(stat_pos), 32'd2);
    check("stat_err_4", 32'(stat_err), 32'd2);
`endif

    frame5(2'd1, 2'd2, 2'd3, 2'd0, 2'd2);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(m_valid), 32'd0);
    check("mid_rst_sready", 32'(s_ready), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_vec", 32'(feat_vec), 32'd0);
    check("mid_rst_class", 32'(m_class), 32'd0);
    check("mid_rst_err", 32'(m_err), 32'd0);
`ifdef TNN_FRAME_STATS_EN
    check("mid_rst_stat", 32'({stat_frames, stat_pos, stat_err}), 32'd0);
`endif
    @(posedge clk); #3;
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      check("post_rst_no_valid", 32'(m_valid), 32'd0);
    end
    frame5(2'd1, 2'd2, 2'd3, 2'd0, 2'd2);
    take("after_rst", 1'b1, 1'b0);

`ifdef TNN_FRAME_STATS_EN
    frame5(2'd0, 2'd3, 2'd0, 2'd3, 2'd1);
    take("st_c0", 1'b0, 1'b0);
    send(2'd3, 1'b0);
    send(2'd3, 1'b1);
    take("st_short", 1'b0, 1'b1);
    check("stat_frames_3", 32'(stat_frames), 32'd3);
    check("stat_pos_3", 32'(stat_pos), 32'd1);
    check("stat_err_3", 32'(stat_err), 32'd1);
    repeat (6) begin
      frame5(2'd1, 2'd2, 2'd3, 2'd0, 2'd2);
      take("st_fill", 1'b1, 1'b0);
    end
    check("stat_frames_sat", 32'(stat_frames), 32'd7);
    check("stat_pos_sat", 32'(stat_pos), 32'd7);
    check("stat_err_hold", 32'(stat_err), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
